// File: rtl/missile_pkg.sv
// Shared types and playfield limits for the missile datapath
// (missile_move and missile_hit_ctrl).
package missile_pkg;

  localparam int unsigned X_MAX       = 639;
  localparam int unsigned Y_MAX       = 479;
  localparam int unsigned POS_W       = 11;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_FLIGHT   = 3'd2,
    ST_HIT      = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_ENEMY  = 2'd1,
    CAUSE_WALL   = 2'd2,
    CAUSE_BOUNDS = 2'd3
  } hit_cause_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a synchronous level.
// The pulse is combinational, so it lands in the same cycle as the rising edge.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: history resets high so a level already asserted at reset release
  // is treated as old, not as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/missile_hit_ctrl.sv
// Fire/collision controller paired with missile_move: one missile in flight,
// frame-based launch timeout and reload cooldown, and hit-cause reporting.
module missile_hit_ctrl
  import missile_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES       = 8,
  parameter int unsigned LAUNCH_TIMEOUT_FRAMES = 2,
  parameter int unsigned X_MAX                 = missile_pkg::X_MAX,
  parameter int unsigned Y_MAX                 = missile_pkg::Y_MAX,
  parameter int unsigned MISSILE_SIZE          = 8,
  parameter int unsigned HIT_COUNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic                       fireKey,
  input  logic                       missileDrawEn,
  input  logic [POS_W-1:0]           missileTopLeftX,
  input  logic [POS_W-1:0]           missileTopLeftY,
  input  logic                       missileDrawingRequest,
  input  logic                       wallDrawingRequest,
  input  logic                       enemyDrawingRequest,
  output logic                       fireReq,
  output logic                       collision,
  output logic [1:0]                 hitCause,
  output logic                       enemyHit,
  output logic [HIT_COUNT_WIDTH-1:0] hitCount,
  output logic                       busy
);

  localparam logic [POS_W-1:0]       X_LIMIT       = POS_W'(X_MAX - MISSILE_SIZE);
  localparam logic [POS_W-1:0]       Y_LIMIT       = POS_W'(Y_MAX - MISSILE_SIZE);
  localparam logic [FRAME_CNT_W-1:0] LAUNCH_LOAD   = FRAME_CNT_W'(LAUNCH_TIMEOUT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] COOLDOWN_LOAD = FRAME_CNT_W'(COOLDOWN_FRAMES);

  state_t                     state, state_next;
  logic [FRAME_CNT_W-1:0]     cnt, cnt_next;
  logic                       wall_flag, wall_next, enemy_flag, enemy_next;
  logic                       fire_next, coll_next, enemy_hit_next, busy_next;
  hit_cause_t                 cause_q, cause_next;
  logic [HIT_COUNT_WIDTH-1:0] count_next;
  logic                       rise, wall_any, enemy_any, out_of_bounds;

  rise_edge_det u_fire_edge (
    .clk   (clk),
    .reset (reset),
    .level (fireKey),
    .pulse (rise)
  );

  // Overlaps seen in the evaluation cycle itself still count for that frame.
  assign wall_any      = wall_flag  | (missileDrawingRequest & wallDrawingRequest);
  assign enemy_any     = enemy_flag | (missileDrawingRequest & enemyDrawingRequest);
  assign out_of_bounds = (missileTopLeftX > X_LIMIT) | (missileTopLeftY > Y_LIMIT);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    wall_next      = 1'b0;
    enemy_next     = 1'b0;
    fire_next      = 1'b0;
    coll_next      = 1'b0;
    enemy_hit_next = 1'b0;
    cause_next     = cause_q;
    count_next     = hitCount;

    case (state)
      ST_IDLE: begin
        if (rise) begin
          fire_next  = 1'b1;
          cnt_next   = LAUNCH_LOAD;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (missileDrawEn) begin
          state_next = ST_FLIGHT;
        end else if (startOfFrame) begin
          if (cnt <= FRAME_CNT_W'(1)) state_next = ST_IDLE;
          else                        cnt_next   = cnt - FRAME_CNT_W'(1);
        end
      end
      ST_FLIGHT: begin
        if (!startOfFrame) begin
          wall_next  = wall_any;
          enemy_next = enemy_any;
        end
        if (startOfFrame && (enemy_any || wall_any || out_of_bounds)) begin
          coll_next  = 1'b1;
          state_next = ST_HIT;
          if (enemy_any) begin
            cause_next     = CAUSE_ENEMY;
            enemy_hit_next = 1'b1;
            if (~&hitCount) count_next = hitCount + HIT_COUNT_WIDTH'(1);
          end else if (wall_any) begin
            cause_next = CAUSE_WALL;
          end else begin
            cause_next = CAUSE_BOUNDS;
          end
        end else if (!missileDrawEn) begin
          state_next = ST_IDLE;
        end
      end
      ST_HIT: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next   = COOLDOWN_LOAD;
          state_next = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (startOfFrame) begin
          if (cnt <= FRAME_CNT_W'(1)) state_next = ST_IDLE;
          else                        cnt_next   = cnt - FRAME_CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wall_flag  <= 1'b0;
      enemy_flag <= 1'b0;
      fireReq    <= 1'b0;
      collision  <= 1'b0;
      enemyHit   <= 1'b0;
      busy       <= 1'b0;
      cause_q    <= CAUSE_NONE;
      hitCount   <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      wall_flag  <= wall_next;
      enemy_flag <= enemy_next;
      fireReq    <= fire_next;
      collision  <= coll_next;
      enemyHit   <= enemy_hit_next;
      busy       <= busy_next;
      cause_q    <= cause_next;
      hitCount   <= count_next;
    end
  end

  assign hitCause = cause_q;

endmodule

// File: tb/tb_missile_hit_ctrl.sv
// Scenario bench for missile_hit_ctrl: a default instance plus a
// no-cooldown, 2-bit-counter instance for the saturation path.
module tb_missile_hit_ctrl;
  import missile_pkg::*;

  typedef struct packed {
    logic [1:0] cause;
    logic       enemy;
    logic [7:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0, key = 1'b0, den = 1'b0;
  logic       sof2 = 1'b0, key2 = 1'b0, den2 = 1'b0;
  logic [10:0] px = 11'd100, py = 11'd100;
  logic       mreq = 1'b0, wreq = 1'b0, ereq = 1'b0;

  logic       fire_req, collision, enemy_hit, busy;
  logic [1:0] hit_cause;
  logic [7:0] hit_count;
  logic       fire_req2, collision2, enemy_hit2, busy2;
  logic [1:0] hit_cause2;
  logic [1:0] hit_count2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] exp_count = 8'd0;
  logic [1:0] exp_count2 = 2'd0;

  always #5 clk = ~clk;

  missile_hit_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .fireKey(key),
    .missileDrawEn(den), .missileTopLeftX(px), .missileTopLeftY(py),
    .missileDrawingRequest(mreq), .wallDrawingRequest(wreq),
    .enemyDrawingRequest(ereq), .fireReq(fire_req), .collision(collision),
    .hitCause(hit_cause), .enemyHit(enemy_hit), .hitCount(hit_count), .busy(busy)
  );

  missile_hit_ctrl #(.COOLDOWN_FRAMES(0), .HIT_COUNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(sof2), .fireKey(key2),
    .missileDrawEn(den2), .missileTopLeftX(px), .missileTopLeftY(py),
    .missileDrawingRequest(mreq), .wallDrawingRequest(wreq),
    .enemyDrawingRequest(ereq), .fireReq(fire_req2), .collision(collision2),
    .hitCause(hit_cause2), .enemyHit(enemy_hit2), .hitCount(hit_count2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit second);
    if (second) sof2 = 1'b1;
    else        sof  = 1'b1;
    tick();
    sof  = 1'b0;
    sof2 = 1'b0;
  endtask

  task automatic push_hit(input logic [1:0] cause);
    if (cause == CAUSE_ENEMY && exp_count != 8'hFF) exp_count = exp_count + 8'd1;
    sb.push_back('{cause: cause, enemy: (cause == CAUSE_ENEMY), count: exp_count});
  endtask

  task automatic fire1();
    key = 1'b0; tick();
    key = 1'b1; tick();
    checks++;
    if (fire_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fire_pulse: fireReq=%b busy=%b required 1 1", fire_req, busy);
    end
    key = 1'b0; tick();
    checks++;
    if (fire_req !== 1'b0) begin
      errors++;
      $display("FAIL fire_width: fireReq=%b required 0", fire_req);
    end
  endtask

  task automatic launch1();
    fire1();
    den = 1'b1;
    tick();
  endtask

  // Evaluation frame: overlaps set by the caller are live in the sof cycle.
  task automatic eval_hit1();
    exp_t e;
    frame(1'b0);
    mreq = 1'b0; wreq = 1'b0; ereq = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: collision=%b with no expected hit", collision);
    end else begin
      e = sb.pop_front();
      if (collision !== 1'b1 || hit_cause !== e.cause || enemy_hit !== e.enemy ||
          hit_count !== e.count) begin
        errors++;
        $display("FAIL hit_result: coll=%b cause=%0d enemyHit=%b count=%0d required 1 %0d %b %0d",
                 collision, hit_cause, enemy_hit, hit_count, e.cause, e.enemy, e.count);
      end
    end
    tick();
    den = 1'b0;
    checks++;
    if (collision !== 1'b0 || enemy_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_width: coll=%b enemyHit=%b required 0 0", collision, enemy_hit);
    end
  endtask

  task automatic cooldown8();
    repeat (8) frame(1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key = 1'b1;
    repeat (2) tick();
    checks++;
    if ({fire_req, collision, enemy_hit, busy, hit_cause, hit_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: fire=%b coll=%b eh=%b busy=%b cause=%0d count=%0d required all 0",
               fire_req, collision, enemy_hit, busy, hit_cause, hit_count);
    end
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick(); tick();
      frame(1'b0);
      checks++;
      if (fire_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL held_key_no_fire: fireReq=%b busy=%b required 0 0 frame %0d", fire_req, busy, f);
      end
    end
  endtask

  task automatic test_launch_timeout();
    fire1();
    frame(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL launch_wait: busy=%b required 1", busy);
    end
    frame(1'b0);
    checks++;
    if (busy !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL launch_timeout: busy=%b coll=%b required 0 0", busy, collision);
    end
  endtask

  task automatic test_enemy_hit();
    launch1();
    mreq = 1'b1; ereq = 1'b1;
    repeat (4) tick();
    mreq = 1'b0; ereq = 1'b0;
    tick();
    push_hit(CAUSE_ENEMY);
    eval_hit1();
  endtask

  task automatic test_cooldown();
    for (int f = 1; f <= 7; f++) begin
      frame(1'b0);
      key = 1'b1; tick();
      checks++;
      if (fire_req !== 1'b0) begin
        errors++;
        $display("FAIL cooldown_press: fireReq=%b required 0 frame %0d", fire_req, f);
      end
      key = 1'b0; tick();
    end
    key = 1'b1;
    frame(1'b0);
    tick();
    checks++;
    if (fire_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_held_key: fireReq=%b busy=%b required 0 0", fire_req, busy);
    end
    fire1();
    repeat (2) frame(1'b0);
  endtask

  task automatic test_priority();
    launch1();
    mreq = 1'b1; wreq = 1'b1; ereq = 1'b1;
    repeat (2) tick();
    mreq = 1'b0; wreq = 1'b0; ereq = 1'b0;
    tick();
    push_hit(CAUSE_ENEMY);
    eval_hit1();
    cooldown8();
    launch1();
    mreq = 1'b1; wreq = 1'b1;
    push_hit(CAUSE_WALL);
    eval_hit1();
    cooldown8();
  endtask

  task automatic test_bounds();
    launch1();
    px = 11'd631; py = 11'd471;
    frame(1'b0);
    checks++;
    if (collision !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bounds_edge: coll=%b busy=%b required 0 1", collision, busy);
    end
    py = 11'd2047;
    push_hit(CAUSE_BOUNDS);
    eval_hit1();
    cooldown8();
    px = 11'd632; py = 11'd100;
    launch1();
    push_hit(CAUSE_BOUNDS);
    eval_hit1();
    cooldown8();
    px = 11'd100;
  endtask

  task automatic test_drawen_drop();
    launch1();
    den = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || collision !== 1'b0 || hit_cause !== CAUSE_BOUNDS) begin
      errors++;
      $display("FAIL drawen_drop: busy=%b coll=%b cause=%0d required 0 0 3", busy, collision, hit_cause);
    end
  endtask

  task automatic test_reset_midflight();
    launch1();
    reset = 1'b1;
    #1;
    checks++;
    if ({fire_req, collision, enemy_hit, busy, hit_cause, hit_count} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: fire=%b coll=%b eh=%b busy=%b cause=%0d count=%0d required all 0",
               fire_req, collision, enemy_hit, busy, hit_cause, hit_count);
    end
    den = 1'b0;
    exp_count = 8'd0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturate_no_cooldown();
    for (int n = 0; n < 4; n++) begin
      key2 = 1'b0; tick();
      key2 = 1'b1; tick();
      key2 = 1'b0;
      checks++;
      if (fire_req2 !== 1'b1) begin
        errors++;
        $display("FAIL fire2: fireReq=%b required 1 shot %0d", fire_req2, n);
      end
      den2 = 1'b1; tick();
      if (exp_count2 != 2'd3) exp_count2 = exp_count2 + 2'd1;
      mreq = 1'b1; ereq = 1'b1;
      frame(1'b1);
      mreq = 1'b0; ereq = 1'b0;
      checks++;
      if (collision2 !== 1'b1 || enemy_hit2 !== 1'b1 || hit_cause2 !== CAUSE_ENEMY ||
          hit_count2 !== exp_count2) begin
        errors++;
        $display("FAIL saturate_hit: coll=%b eh=%b cause=%0d count=%0d required 1 1 1 %0d",
                 collision2, enemy_hit2, hit_cause2, hit_count2, exp_count2);
      end
      tick();
      den2 = 1'b0;
      checks++;
      if (busy2 !== 1'b0 || collision2 !== 1'b0) begin
        errors++;
        $display("FAIL no_cooldown_idle: busy=%b coll=%b required 0 0", busy2, collision2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch_timeout();
    test_enemy_hit();
    test_cooldown();
    test_priority();
    test_bounds();
    test_drawen_drop();
    test_reset_midflight();
    test_saturate_no_cooldown();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/missile_hit_ctrl.md
Name: missile_hit_ctrl

Overview:
- Counterpart of missile_move. Issues the one-cycle fire request that missile_move consumes on its inputKeyPressed port.
- Watches the launched missile's pixel overlaps and its position, and returns the one-cycle collision pulse that missile_move consumes.
- Enforces one missile in flight plus a frame-based reload cooldown; reports hit cause and a saturating enemy-hit count to scoring logic.
- Sits between the keyboard/debounce logic, the VGA object drawing requests and missile_move.

Parameters:
COOLDOWN_FRAMES, 8, frames to wait after a hit before the next shot is accepted (0 = none)
LAUNCH_TIMEOUT_FRAMES, 2, frames to wait in LAUNCH for missileDrawEn before abandoning the shot
X_MAX, 639, rightmost legal pixel column
Y_MAX, 479, bottom legal pixel row
MISSILE_SIZE, 8, missile sprite width/height in pixels
HIT_COUNT_WIDTH, 8, width of hitCount

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
fireKey  in  1  debounced shoot key level
missileDrawEn  in  1  drawEn from missile_move
missileTopLeftX  in  11  missile top-left X
missileTopLeftY  in  11  missile top-left Y
missileDrawingRequest  in  1  current pixel belongs to missile
wallDrawingRequest  in  1  current pixel belongs to a wall
enemyDrawingRequest  in  1  current pixel belongs to an enemy tank
fireReq  out  1  one-cycle pulse to missile_move inputKeyPressed
collision  out  1  one-cycle pulse to missile_move collision
hitCause  out  2  cause of the last hit: 0 none, 1 enemy, 2 wall, 3 bounds; held until the next hit
enemyHit  out  1  one-cycle pulse on an enemy hit
hitCount  out  HIT_COUNT_WIDTH  saturating enemy-hit counter
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE.
  - fireReq, collision, enemyHit, busy all 0; hitCause 0; hitCount 0.
  - Sticky overlap flags cleared; frame counter cleared.
  - Key-edge history register reset to 1, so a key held through reset release does not fire.
- Key edge: rise = fireKey & ~fireKey_q. Evaluated only in IDLE. Edges in any other state are dropped, not queued.
- IDLE:
  - On rise: fireReq=1 for exactly one cycle (the cycle after the edge cycle).
  - Load the frame counter with LAUNCH_TIMEOUT_FRAMES; go to LAUNCH.
- LAUNCH:
  - missileDrawEn=1 → FLIGHT. Clear sticky flags on entry.
  - Otherwise each startOfFrame decrements the counter; at 0 → IDLE with no collision.
- FLIGHT, overlap capture:
  - wallFlag |= missileDrawingRequest & wallDrawingRequest.
  - enemyFlag |= missileDrawingRequest & enemyDrawingRequest.
- FLIGHT, evaluation on startOfFrame:
  - Overlap terms from the same cycle are ORed into the evaluation.
  - Priority: enemy > wall > bounds.
  - Bounds condition: missileTopLeftX > X_MAX-MISSILE_SIZE, or missileTopLeftY > Y_MAX-MISSILE_SIZE. Compare 11-bit unsigned, so negative positions that wrapped to large values count as out of bounds.
  - If any condition holds → HIT, latching hitCause.
  - Flags clear after every evaluation.
- FLIGHT, missileDrawEn falling to 0 without a collision → IDLE silently, no pulses.
- HIT (one cycle):
  - collision=1.
  - If cause is enemy: enemyHit=1, and hitCount increments, saturating at 2^HIT_COUNT_WIDTH-1.
  - Load the counter with COOLDOWN_FRAMES. Go to COOLDOWN, or straight to IDLE when COOLDOWN_FRAMES=0.
- COOLDOWN: counter decrements on each startOfFrame; at 0 → IDLE.
  - A key held down across the cooldown does not fire; a new rising edge is required.
- Timing and widths:
  - All outputs are registered.
  - Latencies: rise → fireReq 1 cycle; startOfFrame evaluation → collision 1 cycle.
  - Frame counters are 8 bits.
- Safety: an illegal state encoding → IDLE.

Decomposition:
- Shared package missile_pkg holds:
  - typedef enum for the states (IDLE, LAUNCH, FLIGHT, HIT, COOLDOWN).
  - typedef enum logic [1:0] for hitCause.
  - Frame-limit constants X_MAX/Y_MAX, shared with missile_move.
- One sub-module: rise_edge_det (clk, reset, level in, pulse out, reset-high history), reusable for other keys.

Test Plan:
1. Reset released with fireKey=1, then held for 3 frames → no fireReq; release then press → fireReq high exactly 1 cycle, busy=1.
2. Fire, missileDrawEn=1, enemy and missile overlap on 4 pixels mid-frame → at the next startOfFrame+1: collision=1 and enemyHit=1 for 1 cycle, hitCause=1, hitCount 0→1.
3. Wall and enemy overlaps in the same frame → hitCause=1 (enemy priority); with wall overlap only → hitCause=2, hitCount unchanged.
4. Missile flying upward so missileTopLeftY wraps to 2047 → collision at the next evaluation with hitCause=3. With X=632, Y=100 (632 > 631) → hitCause=3.
5. After a hit with COOLDOWN_FRAMES=8: key presses in frames 1-7 → no fireReq; a press after the 8th startOfFrame → fireReq. Repeat with COOLDOWN_FRAMES=0 → state returns to IDLE in 1 cycle.
6. Fire with missileDrawEn held 0 → state returns to IDLE after 2 startOfFrame pulses with no collision. Force hitCount to 255 then score an enemy hit → hitCount stays 255. Assert reset mid-FLIGHT → all outputs 0 immediately.
